rect_cmd_queue: RTL and testbench
=================================

# rect_cmd_queue

Buffers rectangle-draw commands from game/UI logic and issues them one at a time to the rectangle drawer over its go/done handshake. Commands are clipped to the 160x120 VGA frame on entry. Commands that are off-screen or zero-sized are discarded and counted. Sits directly upstream of the rectangle drawer datapath/control pair and shares its clock and reset.

## Interface
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- ADDR_W, 3, log2(DEPTH)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  producer offers a command this cycle
- cmd_ready  out  1  queue can accept; = (count != DEPTH)
- cmd_x0  in  8  left column, 0..159 valid
- cmd_y0  in  7  top row, 0..119 valid
- cmd_width  in  8  width in pixels
- cmd_height  in  7  height in pixels
- cmd_rgb  in  3  colour
- go  out  1  one-cycle start pulse to drawer
- x0 / y0 / width / height / RGB  out  8/7/8/7/3  held command to drawer, stable from the go cycle until the next issue
- draw_done  in  1  drawer's one-cycle done pulse
- count  out  ADDR_W+1  stored entries
- drop_count  out  8  saturating count of discarded commands
- idle  out  1  count==0 and FSM in S_IDLE

## Operation
- A push is accepted on an edge where cmd_valid && cmd_ready. No push is accepted while the queue is full.
- Clip at push, combinationally on the inputs:
  - Discard the command (not stored, drop_count+1 saturating at 255) if cmd_x0≥160, cmd_y0≥120, cmd_width==0, or cmd_height==0.
  - Otherwise store width' = min(cmd_width, 160−cmd_x0) and height' = min(cmd_height, 120−cmd_y0).
  - Compute the limits in 9-bit/8-bit unsigned so that cmd_x0+cmd_width cannot wrap.
- A discarded command still consumes the handshake: cmd_ready is asserted, so the producer sees it accepted.
- Storage is a circular FIFO with write pointer wp and read pointer rp (ADDR_W bits, wrapping DEPTH−1→0) and a separate count register.
- FSM:
  - S_IDLE: if count≠0, pop the head into the x0..RGB output registers, rp+1, go to S_GO. Otherwise stay.
  - S_GO: go=1 for exactly this cycle, then go to S_WAIT. The outputs are already stable, so the drawer latches them on this edge.
  - S_WAIT: wait for draw_done, then go to S_IDLE. Ignore cmd traffic here except for pushes.
- A push and a pop on the same edge leave count unchanged. Both pointers advance.
- draw_done outside S_WAIT is ignored.
- At most one command is outstanding at the drawer at any time.

## Timing
- Reset values: go=0, x0=y0=width=height=RGB=0, count=0, drop_count=0, wp=rp=0, state=S_IDLE, idle=1, cmd_ready=1.
- Reset takes effect immediately and is asynchronous. A reset in S_GO or S_WAIT drops all queued and outstanding commands. The drawer resets on the same signal.
- Issue latency from an empty, idle queue:
  - Push accepted at edge E0; pop at E1; go high in the cycle E1→E2.
- Back-to-back issue:
  - draw_done high in cycle C; state is S_IDLE after that edge; go high in cycle C+2 if count≠0.
- cmd_ready, idle and count are registered-state derived. They reflect a push or pop in the cycle after its edge.
- Full boundary: while count==DEPTH, cmd_ready=0 even in a cycle where a pop occurs on the closing edge. cmd_ready rises the following cycle.
- Empty boundary: a push into an empty queue while in S_IDLE is popped on the next edge, never the same edge.

## Test plan
- Reset, then push (10,20,4,3,rgb=5) → go high exactly one cycle, 1 cycle after accept, with x0=10, y0=20, width=4, height=3, RGB=5; no further go; idle=0 until draw_done, then idle=1.
- Push (150,115,20,10,rgb=2) → issued width=10, height=5. Push (160,0,5,5) and (5,5,0,3) → no go, drop_count=2, count=0.
- Hold draw_done low and push 10 commands on consecutive cycles → first issued, count reaches 8, cmd_ready=0 after the 9th accept, 10th stalls. One draw_done → count=7, 10th accepted next cycle.
- Push A, B, C; pulse draw_done 5 cycles after each go → go pulses carry A, B, C in order; each go occurs 2 cycles after the preceding draw_done.
- With 3 queued and state S_WAIT, assert reset for 1 cycle mid-cycle → go=0, outputs=0, count=0, cmd_ready=1, idle=1 immediately. A later draw_done causes no go.
- Push 256+ off-screen commands → drop_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/rect_cmd_queue.sv
// Command FIFO in front of the rectangle drawer: clips commands to the 160x120 frame
// on entry, drops degenerate ones, and issues one command at a time over go/draw_done.
module rect_cmd_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x0,
    input  logic [6:0]        cmd_y0,
    input  logic [7:0]        cmd_width,
    input  logic [6:0]        cmd_height,
    input  logic [2:0]        cmd_rgb,
    output logic              go,
    output logic [7:0]        x0,
    output logic [6:0]        y0,
    output logic [7:0]        width,
    output logic [6:0]        height,
    output logic [2:0]        RGB,
    input  logic              draw_done,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        drop_count,
    output logic              idle
);

    typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] c;
    } cmd_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    cmd_t              mem_q [DEPTH];
    cmd_t              out_q;
    state_t            state_q;
    logic [ADDR_W-1:0] wp_q, rp_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        drop_q;
    logic              go_q;

    logic [8:0] x_room;
    logic [7:0] y_room;
    logic [7:0] w_clip;
    logic [6:0] h_clip;
    logic       off, accept, push, drop, pop;

    // Rooms are only meaningful when the origin is on-screen; wider math keeps x0+w from wrapping.
    assign x_room = 9'd160 - {1'b0, cmd_x0};
    assign y_room = 8'd120 - {1'b0, cmd_y0};
    assign w_clip = ({1'b0, cmd_width}  > x_room) ? x_room[7:0] : cmd_width;
    assign h_clip = ({1'b0, cmd_height} > y_room) ? y_room[6:0] : cmd_height;
    assign off    = (cmd_x0 >= 8'd160) || (cmd_y0 >= 7'd120) ||
                    (cmd_width == 8'd0) || (cmd_height == 7'd0);

    assign cmd_ready = (count_q != FULL);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && !off;
    assign drop      = accept && off;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wp_q] <= '{x: cmd_x0, y: cmd_y0, w: w_clip, h: h_clip, c: cmd_rgb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
            go_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push)
                wp_q <= wp_q + 1'b1;
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        out_q   <= mem_q[rp_q];
                        rp_q    <= rp_q + 1'b1;
                        go_q    <= 1'b1;
                        state_q <= S_GO;
                    end
                end
                S_GO: begin
                    go_q    <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (draw_done)
                        state_q <= S_IDLE;
                end
                default: begin
                    go_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign go         = go_q;
    assign x0         = out_q.x;
    assign y0         = out_q.y;
    assign width      = out_q.w;
    assign height     = out_q.h;
    assign RGB        = out_q.c;
    assign count      = count_q;
    assign drop_count = drop_q;
    assign idle       = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_rect_cmd_queue.sv
// Bench for rect_cmd_queue: random commands against a queue-based model of clipping,
// dropping, ordering and issue timing.
module tb_rect_cmd_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x0 = '0;
    logic [6:0]  cmd_y0 = '0;
    logic [7:0]  cmd_width = '0;
    logic [6:0]  cmd_height = '0;
    logic [2:0]  cmd_rgb = '0;
    logic        go;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [7:0]  width;
    logic [6:0]  height;
    logic [2:0]  RGB;
    logic        draw_done = 1'b0;
    logic [3:0]  count;
    logic [7:0]  drop_count;
    logic        idle;

    rect_cmd_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_width(cmd_width),
        .cmd_height(cmd_height), .cmd_rgb(cmd_rgb),
        .go(go), .x0(x0), .y0(y0), .width(width), .height(height), .RGB(RGB),
        .draw_done(draw_done), .count(count), .drop_count(drop_count), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, w, h, c;
    } cmd_t;

    cmd_t exp_q[$];
    int   drops = 0;
    int   checks = 0;
    int   errors = 0;

    logic [32:0] outs;
    assign outs = {x0, y0, width, height, RGB};

    function automatic logic [32:0] pk(cmd_t e);
        return {8'(e.x), 7'(e.y), 8'(e.w), 7'(e.h), 3'(e.c)};
    endfunction

    function automatic int exp_drops();
        return (drops > 255) ? 255 : drops;
    endfunction

    // Reference: a command is either dropped or stored clipped to the frame.
    function automatic void model_push(cmd_t r);
        cmd_t s;
        if (r.x >= 160 || r.y >= 120 || r.w == 0 || r.h == 0) begin
            drops++;
        end else begin
            s   = r;
            s.w = (r.w < 160 - r.x) ? r.w : 160 - r.x;
            s.h = (r.h < 120 - r.y) ? r.h : 120 - r.y;
            exp_q.push_back(s);
        end
    endfunction

    function automatic cmd_t rnd_on();
        cmd_t r;
        r.x = int'($urandom_range(0, 159));
        r.y = int'($urandom_range(0, 119));
        r.w = int'($urandom_range(1, 255));
        r.h = int'($urandom_range(1, 127));
        r.c = int'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic cmd_t mk(int x, int y, int w, int h, int c);
        cmd_t r;
        r.x = x; r.y = y; r.w = w; r.h = h; r.c = c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(cmd_t r);
        cmd_valid  = 1'b1;
        cmd_x0     = 8'(r.x);
        cmd_y0     = 7'(r.y);
        cmd_width  = 8'(r.w);
        cmd_height = 7'(r.h);
        cmd_rgb    = 3'(r.c);
    endtask

    // Entered with one command outstanding at the drawer; retires it and every queued one.
    task automatic drain();
        cmd_t e;
        bit   bad;
        while (exp_q.size() > 0) begin
            bad = 0;
            repeat (5) begin
                tick();
                if (go !== 1'b0) bad = 1;
            end
            checks++;
            if (bad) begin errors++; $display("FAIL drain_extra_go: go seen while waiting, want none"); end
            draw_done = 1'b1; tick(); draw_done = 1'b0;
            tick();
            e = exp_q.pop_front();
            checks++;
            if (go !== 1'b1 || outs !== pk(e)) begin
                errors++;
                $display("FAIL drain_issue: go=%0b outs=%h, want go=1 outs=%h", go, outs, pk(e));
            end
        end
        repeat (5) tick();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        tick(); tick();
        checks++;
        if (go !== 1'b0 || idle !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL drain_end: go=%0b idle=%0b count=%0d, want 0 1 0", go, idle, count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (go !== 1'b0 || outs !== 33'd0) begin
            errors++; $display("FAIL reset_outs: go=%0b outs=%h, want 0 0", go, outs);
        end
        checks++;
        if (count !== 4'd0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_counts: count=%0d drop=%0d, want 0 0", count, drop_count);
        end
        checks++;
        if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL reset_flags: ready=%0b idle=%0b, want 1 1", cmd_ready, idle);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        drops = 0;
        tick();
    endtask

    task automatic test_single();
        cmd_t e;
        bit   bad = 0;
        drive(mk(10, 20, 4, 3, 5)); model_push(mk(10, 20, 4, 3, 5));
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (count !== 4'd1 || go !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL single_accept: count=%0d go=%0b idle=%0b, want 1 0 0", count, go, idle);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (go !== 1'b1 || outs !== pk(e) || x0 !== 8'd10 || width !== 8'd4 || RGB !== 3'd5) begin
            errors++; $display("FAIL single_go: go=%0b outs=%h, want 1 %h", go, outs, pk(e));
        end
        repeat (6) begin
            tick();
            if (go !== 1'b0 || idle !== 1'b0 || outs !== pk(e)) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL single_hold: go/idle/outs changed while waiting, want go=0 idle=0"); end
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        checks++;
        if (idle !== 1'b1 || go !== 1'b0) begin
            errors++; $display("FAIL single_done: idle=%0b go=%0b, want 1 0", idle, go);
        end
    endtask

    task automatic test_clip();
        cmd_t e;
        bit   bad = 0;
        drive(mk(150, 115, 20, 10, 2)); model_push(mk(150, 115, 20, 10, 2));
        tick(); cmd_valid = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (go !== 1'b1 || width !== 8'd10 || height !== 7'd5 || outs !== pk(e)) begin
            errors++; $display("FAIL clip_edge: go=%0b w=%0d h=%0d, want 1 10 5", go, width, height);
        end
        repeat (3) tick();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        drive(mk(160, 0, 5, 5, 1)); model_push(mk(160, 0, 5, 5, 1));
        tick();
        drive(mk(5, 5, 0, 3, 1)); model_push(mk(5, 5, 0, 3, 1));
        tick(); cmd_valid = 1'b0;
        checks++;
        if (drop_count !== 8'd2 || drop_count !== 8'(exp_drops()) || count !== 4'd0) begin
            errors++; $display("FAIL clip_drop: drop=%0d count=%0d, want 2 0", drop_count, count);
        end
        repeat (4) begin
            tick();
            if (go !== 1'b0 || idle !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL clip_no_go: dropped command issued, want no go"); end
    endtask

    task automatic test_full();
        cmd_t c[10];
        cmd_t e;
        int   want;
        foreach (c[i]) c[i] = rnd_on();
        for (int i = 0; i < 9; i++) begin
            drive(c[i]);
            tick();
            model_push(c[i]);
            want = (i == 0) ? 1 : i;
            checks++;
            if (count !== 4'(want)) begin
                errors++; $display("FAIL full_fill[%0d]: count=%0d, want %0d", i, count, want);
            end
            if (i == 1) begin
                e = exp_q.pop_front();
                checks++;
                if (go !== 1'b1 || outs !== pk(e)) begin
                    errors++; $display("FAIL full_first_go: go=%0b outs=%h, want 1 %h", go, outs, pk(e));
                end
            end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: ready=%0b, want 0", cmd_ready); end
        drive(c[9]);
        repeat (3) begin
            tick();
            checks++;
            if (count !== 4'd8 || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL full_stall: count=%0d ready=%0b, want 8 0", count, cmd_ready);
            end
        end
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        checks++;
        if (count !== 4'd8 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL full_pop_cycle: count=%0d ready=%0b, want 8 0", count, cmd_ready);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (count !== 4'd7 || cmd_ready !== 1'b1 || go !== 1'b1 || outs !== pk(e)) begin
            errors++; $display("FAIL full_after_pop: count=%0d ready=%0b go=%0b outs=%h, want 7 1 1 %h",
                               count, cmd_ready, go, outs, pk(e));
        end
        tick();
        model_push(c[9]);
        cmd_valid = 1'b0;
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL full_tenth: count=%0d, want 8", count); end
        drain();
    endtask

    task automatic test_back_to_back();
        cmd_t a = rnd_on(), b = rnd_on(), c = rnd_on();
        cmd_t e;
        drive(a); tick(); model_push(a);
        drive(b); tick(); model_push(b);
        e = exp_q.pop_front();
        checks++;
        if (go !== 1'b1 || outs !== pk(e)) begin
            errors++; $display("FAIL b2b_first: go=%0b outs=%h, want 1 %h", go, outs, pk(e));
        end
        drive(c); tick(); model_push(c);
        cmd_valid = 1'b0;
        checks++;
        if (go !== 1'b0 || count !== 4'd2) begin
            errors++; $display("FAIL b2b_queued: go=%0b count=%0d, want 0 2", go, count);
        end
        drain();
    endtask

    task automatic test_random();
        cmd_t r;
        cmd_t e;
        bit   issued;
        for (int round = 0; round < 4; round++) begin
            issued = 0;
            for (int i = 0; i < 10; i++) begin
                if (i < 8) begin
                    r.x = int'($urandom_range(0, 255));
                    r.y = int'($urandom_range(0, 127));
                    r.w = int'($urandom_range(0, 255));
                    r.h = int'($urandom_range(0, 127));
                    r.c = int'($urandom_range(0, 7));
                    drive(r);
                end else begin
                    cmd_valid = 1'b0;
                end
                tick();
                if (i < 8) model_push(r);
                if (go === 1'b1) begin
                    checks++;
                    if (issued || exp_q.size() == 0) begin
                        errors++; $display("FAIL rand_spurious_go: round %0d cycle %0d, want no go", round, i);
                    end else begin
                        e = exp_q.pop_front();
                        if (outs !== pk(e)) begin
                            errors++; $display("FAIL rand_issue: outs=%h, want %h", outs, pk(e));
                        end
                    end
                    issued = 1;
                end
            end
            checks++;
            if (drop_count !== 8'(exp_drops()) || count !== 4'(exp_q.size())) begin
                errors++; $display("FAIL rand_counts: drop=%0d count=%0d, want %0d %0d",
                                   drop_count, count, exp_drops(), exp_q.size());
            end
            checks++;
            if (!issued && exp_q.size() != 0) begin
                errors++; $display("FAIL rand_no_issue: go never seen, want one go");
            end
            if (issued) drain();
        end
    endtask

    task automatic test_reset_mid();
        cmd_t a[4];
        cmd_t e;
        bit   bad = 0;
        foreach (a[i]) a[i] = rnd_on();
        for (int i = 0; i < 4; i++) begin
            drive(a[i]); tick(); model_push(a[i]);
            if (i == 1) begin
                e = exp_q.pop_front();
                checks++;
                if (go !== 1'b1 || outs !== pk(e)) begin
                    errors++; $display("FAIL rmid_go: go=%0b outs=%h, want 1 %h", go, outs, pk(e));
                end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (count !== 4'd3 || idle !== 1'b0) begin
            errors++; $display("FAIL rmid_queued: count=%0d idle=%0b, want 3 0", count, idle);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (go !== 1'b0 || outs !== 33'd0 || count !== 4'd0 || cmd_ready !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL rmid_async: go=%0b outs=%h count=%0d ready=%0b idle=%0b, want 0 0 0 1 1",
                               go, outs, count, cmd_ready, idle);
        end
        @(posedge clk); #4;
        reset = 1'b0;
        exp_q.delete();
        drops = 0;
        tick();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        repeat (5) begin
            tick();
            if (go !== 1'b0 || idle !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rmid_stale_done: go after reset, want none"); end
    endtask

    task automatic test_drop_sat();
        cmd_t r;
        bit   bad = 0;
        for (int i = 0; i < 262; i++) begin
            r = rnd_on();
            case ($urandom_range(0, 3))
                0: r.x = int'($urandom_range(160, 255));
                1: r.y = int'($urandom_range(120, 127));
                2: r.w = 0;
                default: r.h = 0;
            endcase
            drive(r);
            tick();
            model_push(r);
            if (cmd_ready !== 1'b1 || go !== 1'b0 || count !== 4'd0) bad = 1;
            if (i == 199) begin
                checks++;
                if (drop_count !== 8'(exp_drops())) begin
                    errors++; $display("FAIL sat_mid: drop=%0d, want %0d", drop_count, exp_drops());
                end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL sat_side_effect: ready/go/count disturbed by drops"); end
        checks++;
        if (drop_count !== 8'd255 || drop_count !== 8'(exp_drops())) begin
            errors++; $display("FAIL sat_final: drop=%0d, want 255", drop_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_drop_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
